// File: rtl/square5_pkg.sv
// rtl/square5_pkg.sv - shared types, widths and round-robin helper for the square5 arbiter
package square5_pkg;

    localparam int SQ_DW = 5;
    localparam int SQ_RW = 10;

    typedef logic [SQ_DW-1:0] sq_operand_t;
    typedef logic [SQ_RW-1:0] sq_result_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic int unsigned rr_next(int unsigned ptr, int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/square5_arbiter_if.sv
// rtl/square5_arbiter_if.sv - requester and response handshake bundle for square5_arbiter
interface square5_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 5,
    parameter int IDW  = $clog2(NREQ)
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*DW-1:0]    rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               busy;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/square5_core.sv
// rtl/square5_core.sv - stateless 5-bit unsigned squarer
module square5_core
    import square5_pkg::*;
(
    input  sq_operand_t op,
    output sq_result_t  sq
);
    assign sq = sq_result_t'(op) * sq_result_t'(op);
endmodule

// File: rtl/square5_arbiter.sv
// rtl/square5_arbiter.sv - round-robin share of one squarer; optional SQUARE5_ARBITER_STATS_EN grant counters
module square5_arbiter
    import square5_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 5,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    square5_arbiter_if.slave    bus
`ifdef SQUARE5_ARBITER_STATS_EN
    ,
    output logic [NREQ*16-1:0]  stat_grants
`endif
);

    if (DW != SQ_DW) begin : g_bad_dw
        $error("square5_arbiter: DW must be 5");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("square5_arbiter: NREQ must be 2..8");
    end

    slot_state_t    state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt;
    logic           found;
    logic           slot_free;
    logic           xfer;
    sq_operand_t    op;
    sq_result_t     sq;

    assign slot_free = (state == SLOT_EMPTY) || bus.rsp_ready;
    assign xfer      = rst_n && slot_free && found;

    // Search ptr, ptr+1, ... with wrap; one extra bit keeps the sum from overflowing.
    always_comb begin
        logic [IDW:0] s;
        found = 1'b0;
        gnt   = '0;
        s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = {1'b0, ptr} + (IDW+1)'(k);
            if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
            if (!found && bus.req_valid[s[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = s[IDW-1:0];
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (xfer) bus.req_ready[gnt] = 1'b1;
    end

    always_comb begin
        op = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) op = bus.req_data[i*DW +: DW];
        end
    end

    square5_core u_core (
        .op (op),
        .sq (sq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SLOT_EMPTY;
            ptr          <= '0;
            bus.rsp_data <= '0;
            bus.rsp_id   <= '0;
        end else if (xfer) begin
            state        <= SLOT_FULL;
            ptr          <= IDW'(rr_next(32'(gnt), NREQ));
            bus.rsp_data <= sq;
            bus.rsp_id   <= gnt;
        end else if (state == SLOT_FULL && bus.rsp_ready) begin
            state        <= SLOT_EMPTY;
        end
    end

    assign bus.rsp_valid = (state == SLOT_FULL);
    assign bus.busy      = bus.rsp_valid || (|bus.req_valid);

`ifdef SQUARE5_ARBITER_STATS_EN
    logic [15:0] grant_cnt [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
        end else if (xfer && grant_cnt[gnt] != 16'hFFFF) begin
            grant_cnt[gnt] <= grant_cnt[gnt] + 16'd1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        assign stat_grants[i*16 +: 16] = grant_cnt[i];
    end
`endif

endmodule

// File: tb/tb_square5_arbiter.sv
// tb/tb_square5_arbiter.sv - directed self-checking bench for square5_arbiter
module tb_square5_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 5;
    localparam int IDW  = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    square5_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

`ifdef SQUARE5_ARBITER_STATS_EN
    logic [NREQ*16-1:0] stat_grants;
`endif

    square5_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus)
`ifdef SQUARE5_ARBITER_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // per-cycle expectations for the full round-robin sweep from ptr=0
    logic [3:0] exp_rdy [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [9:0] exp_sq  [4] = '{10'd0, 10'd49, 10'd4, 10'd961};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        #2;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        check("reset_rsp_data",  32'(bus.rsp_data), 0);
        check("reset_rsp_id",    32'(bus.rsp_id), 0);
        check("reset_req_ready", 32'(bus.req_ready), 0);
        check("reset_busy",      32'(bus.busy), 1);
        step();
        bus.req_valid = '0;
        rst_n = 1'b1;
        #1;
        check("idle_busy", 32'(bus.busy), 0);

        // single requester
        bus.req_valid = 4'b0001;
        bus.req_data  = {5'd0, 5'd0, 5'd0, 5'd13};
        bus.rsp_ready = 1'b1;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'b0001);
        step();
        bus.req_valid = '0;
        check("single_valid", 32'(bus.rsp_valid), 1);
        check("single_data",  32'(bus.rsp_data), 169);
        check("single_id",    32'(bus.rsp_id), 0);
        step();
        check("single_drain", 32'(bus.rsp_valid), 0);

        // all requesters, full sweep from ptr=0
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = {5'd31, 5'd2, 5'd7, 5'd0};
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ready", 32'(bus.req_ready), 32'(exp_rdy[i]));
            step();
            check("rr_valid", 32'(bus.rsp_valid), 1);
            check("rr_data",  32'(bus.rsp_data), 32'(exp_sq[i]));
            check("rr_id",    32'(bus.rsp_id), i);
        end
        check("rr_wrap_ready", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        step();
        check("rr_drain", 32'(bus.rsp_valid), 0);

        // backpressure: ptr=0, load req0=5 and hold it
        bus.req_valid = 4'b0001;
        bus.req_data  = {5'd0, 5'd0, 5'd6, 5'd5};
        bus.rsp_ready = 1'b0;
        step();
        check("bp_load_data", 32'(bus.rsp_data), 25);
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready_low", 32'(bus.req_ready), 0);
            check("bp_valid",     32'(bus.rsp_valid), 1);
            check("bp_data",      32'(bus.rsp_data), 25);
            check("bp_id",        32'(bus.rsp_id), 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.req_ready), 32'b0010);
        step();
        bus.req_valid = '0;
        check("bp_new_valid", 32'(bus.rsp_valid), 1);
        check("bp_new_data",  32'(bus.rsp_data), 36);
        check("bp_new_id",    32'(bus.rsp_id), 1);
        step();
        check("bp_drain", 32'(bus.rsp_valid), 0);

        // fairness: ptr=2, req0 held, req2 arrives after req0's grant
        bus.req_valid = 4'b0001;
        bus.req_data  = {5'd0, 5'd9, 5'd0, 5'd3};
        step();
        check("fair_req0_id", 32'(bus.rsp_id), 0);
        bus.req_valid = 4'b0101;
        #1;
        check("fair_req2_ready", 32'(bus.req_ready), 32'b0100);
        step();
        check("fair_req2_id",   32'(bus.rsp_id), 2);
        check("fair_req2_data", 32'(bus.rsp_data), 81);
        bus.req_valid = 4'b0001;
        #1;
        check("fair_back_ready", 32'(bus.req_ready), 32'b0001);
        step();
        check("fair_back_data", 32'(bus.rsp_data), 9);

        // reset while FULL
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        #1;
        check("rst_pre_valid", 32'(bus.rsp_valid), 1);
        check("rst_pre_busy",  32'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.rsp_valid), 0);
        check("rst_mid_data",  32'(bus.rsp_data), 0);
        check("rst_mid_id",    32'(bus.rsp_id), 0);
        step();
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        check("rst_ptr_zero", 32'(bus.req_ready), 32'b0001);
        bus.req_valid = '0;
        step();

`ifdef SQUARE5_ARBITER_STATS_EN
        do_reset();
        check("stat_reset", 32'(stat_grants[31:0]), 0);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0001;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) step();
        bus.req_valid = '0;
        step();
        check("stat_req0_sat", 32'(stat_grants[15:0]), 32'hFFFF);
        check("stat_req1",     32'(stat_grants[31:16]), 3);
        check("stat_req2",     32'(stat_grants[47:32]), 0);
        check("stat_req3",     32'(stat_grants[63:48]), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
